i2c_reg_target: RTL and testbench
=================================

# i2c_reg_target

I2C target (responder) that exposes an 8-bit-addressed register file over the two-wire bus. It is the counterpart to the I2C initiator used for HDMI transmitter configuration. It accepts the same `[slave address, sub-address, data]` write framing and adds register reads via repeated START. It serves as the bus-functional register model of the transmitter in system simulation and as an on-chip configuration target reachable from an external I2C master.

## Interface
Parameters:
- `DEV_ADDR`, 7'h39 — 7-bit target address (8-bit write address 0x72, read 0x73).
- `FILTER_LEN`, 3 — consecutive equal iCLK samples required before a filtered SCL/SDA level changes.

Ports:
- `iCLK`  in  1  system clock, ≥20× SCL rate.
- `iRST_N`  in  1  reset; one clock; reset is asynchronous and active-low.
- `I2C_SCL`  in  1  bus clock (target never stretches).
- `I2C_SDA`  inout  1  open-drain data; driven 0 or Z only.
- `REG_ADDR`  out  8  register pointer.
- `REG_WDATA`  out  8  write data; valid when REG_WE=1.
- `REG_WE`  out  1  one-cycle write strobe.
- `REG_RDATA`  in  8  read data for REG_ADDR; sampled when REG_RE=1.
- `REG_RE`  out  1  one-cycle read strobe.
- `BUSY`  out  1  high from START to STOP.

## Operation
- Reset values: SDA = Z, REG_ADDR = 0, REG_WDATA = 0, REG_WE = 0, REG_RE = 0, BUSY = 0, state = IDLE.
- Input conditioning: 2-FF synchronizer plus FILTER_LEN glitch filter on each line.
- Condition detection on the filtered lines:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise and SCL fall events.
- Bits are sampled on SCL rise, MSB first. SDA drive changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE → ADDR on START.
- ADDR: 8 bits.
  - Upper 7 bits == DEV_ADDR: drive ACK → ADDR_ACK.
    - R/W=0 → SUB.
    - R/W=1 → RDATA.
  - Otherwise, including general call 0x00: no ACK → IGNORE.
- SUB: byte → REG_ADDR, ACK → WDATA.
- WDATA: byte → REG_WDATA, then a REG_WE pulse at the SCL fall that starts the ACK. ACK, then pointer advance (see Configuration), then loop in WDATA.
- RDATA:
  - On the SCL fall that ends the preceding ACK: pulse REG_RE, latch REG_RDATA into the shift register, drive bit 7.
  - After 8 bits, release SDA and sample the master's ACK/NACK on SCL rise.
  - ACK: advance pointer, load next byte.
  - NACK: → IGNORE.
- ACK phase: SDA driven low from the SCL fall after bit 8 until the next SCL fall.
- START in any state → ADDR. SDA is released and REG_ADDR is retained (repeated-start read).
- STOP in any state → IDLE, SDA released, BUSY = 0.
- IGNORE: SDA released; leaves only on START or STOP.
- Pointer arithmetic is 8-bit modulo: 0xFF + 1 = 0x00.

## Timing
- Bus-to-core latency: 2 + FILTER_LEN iCLK cycles from a pad edge to the internal event.
- SDA drive/release occurs 1 iCLK after the internal SCL-fall event. Hold time after the SCL fall is therefore ≥ 3 + FILTER_LEN cycles.
- REG_WE and REG_RE are exactly 1 iCLK wide. REG_ADDR is stable from that cycle until the next pointer update.
- REG_RDATA must be valid combinationally in the REG_RE cycle, with zero wait states.
- BUSY rises 1 cycle after the START event and falls 1 cycle after the STOP event.
- Async reset mid-transfer releases SDA immediately, without waiting for a clock edge.

## Configuration
- `I2C_TARGET_AUTOINC_EN` defined: the pointer increments after every written data byte and after every read byte the master ACKs.
- Macro undefined: the pointer changes only via SUB. Burst writes all target the same register, and burst reads repeat the same register.

## Structure
- Package `i2c_pkg`:
  - `i2c_state_t` enum.
  - Default address constant `I2C_ADV_ADDR = 7'h39`.
  - Bit-count width constant.
- Sub-module `i2c_line_filter`: synchronizer, glitch filter and edge/START/STOP detection. Instantiated once, handling both lines.
- The top level holds the FSM, shift register, pointer and open-drain driver.

## Test plan
- Write 0x72, 0x41, 0x10, STOP → target ACKs 3 bytes; one REG_WE with REG_ADDR=0x41, REG_WDATA=0x10; BUSY=0 after STOP.
- Burst 0x72, 0xA4, 0x08, 0x04:
  - With AUTOINC → WE at (0xA4, 0x08) then (0xA5, 0x04).
  - Without AUTOINC → both WEs at 0xA4.
- 0x72, 0x16, Sr, 0x73; master ACK, ACK, NACK; model REG_RDATA = ~REG_ADDR → SDA returns 0xE9, 0xE8, 0xE7 (AUTOINC); 3 REG_RE pulses; SDA released after the NACK.
- Address 0x74 → SDA high in the 9th clock; no REG_WE/REG_RE until STOP; next 0x72 transfer ACKed.
- Sub-address 0xFF, data 0x11, 0x22 (AUTOINC) → WE at 0xFF then 0x00.
- Assert iRST_N low while the target drives an ACK → SDA = Z within the same cycle; all outputs at reset values; a 1-iCLK SCL glitch after reset produces no bit.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type and constants for the I2C register target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2c_state_t;
  localparam logic [6:0] I2C_ADV_ADDR = 7'h39;
  localparam int BIT_CNT_W = 4;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizes and deglitches SCL/SDA, then flags SCL edges and START/STOP
module i2c_line_filter import i2c_pkg::*; #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] raw, filt, prev;
  assign raw = {scl_in, sda_in};
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic s1, s2, f, p;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        f <= 1'b1;
        p <= 1'b1;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        p <= f;
        if (s2 == f) cnt <= '0;
        else if (cnt == CW'(FILTER_LEN - 1)) begin
          f <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign filt[i] = f;
    assign prev[i] = p;
  end
  assign sda = filt[0];
  assign scl_rise = filt[1] & ~prev[1];
  assign scl_fall = ~filt[1] & prev[1];
  assign start = filt[1] & prev[1] & prev[0] & ~filt[0];
  assign stop = filt[1] & prev[1] & ~prev[0] & filt[0];
endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing an 8-bit-addressed register file (writes, repeated-START reads)
// Optional: define I2C_TARGET_AUTOINC_EN to auto-increment the register pointer per data byte.
module i2c_reg_target import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = I2C_ADV_ADDR,
  parameter int FILTER_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       REG_RE,
  output logic       BUSY
);
  i2c_state_t state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0] shreg, next_ptr;
  logic sda_oe, rw, nack, sda, scl_rise, scl_fall, start, stop, byte_done;
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk(iCLK), .rst_n(iRST_N), .scl_in(I2C_SCL), .sda_in(I2C_SDA),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;
  assign byte_done = bit_cnt == BIT_CNT_W'(8);
`ifdef I2C_TARGET_AUTOINC_EN
  assign next_ptr = REG_ADDR + 8'd1;
`else
  assign next_ptr = REG_ADDR;
`endif
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      sda_oe <= 1'b0;
      rw <= 1'b0;
      nack <= 1'b0;
      REG_ADDR <= '0;
      REG_WDATA <= '0;
      REG_WE <= 1'b0;
      REG_RE <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      REG_WE <= 1'b0;
      REG_RE <= 1'b0;
      if (stop) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        BUSY <= 1'b0;
      end else if (start) begin
        state <= ADDR;
        bit_cnt <= '0;
        sda_oe <= 1'b0;
        BUSY <= 1'b1;
      end else begin
        // read bytes shift through shreg too, so bit 7 is always the next bit to drive
        if (scl_rise && state inside {ADDR, SUB, WDATA, RDATA}) begin
          shreg <= {shreg[6:0], sda};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (scl_rise && state == RDATA_ACK) nack <= sda;
        if (REG_RE) begin
          shreg <= REG_RDATA;
          sda_oe <= ~REG_RDATA[7];
        end
        if (scl_fall)
          case (state)
            ADDR: if (byte_done) begin
              bit_cnt <= '0;
              rw <= shreg[0];
              sda_oe <= shreg[7:1] == DEV_ADDR;
              state <= shreg[7:1] == DEV_ADDR ? ADDR_ACK : IGNORE;
            end
            ADDR_ACK: begin
              bit_cnt <= '0;
              sda_oe <= 1'b0;
              REG_RE <= rw;
              state <= rw ? RDATA : SUB;
            end
            SUB: if (byte_done) begin
              REG_ADDR <= shreg;
              sda_oe <= 1'b1;
              state <= SUB_ACK;
            end
            SUB_ACK: begin
              bit_cnt <= '0;
              sda_oe <= 1'b0;
              state <= WDATA;
            end
            WDATA: if (byte_done) begin
              REG_WDATA <= shreg;
              REG_WE <= 1'b1;
              sda_oe <= 1'b1;
              state <= WDATA_ACK;
            end
            WDATA_ACK: begin
              bit_cnt <= '0;
              sda_oe <= 1'b0;
              REG_ADDR <= next_ptr;
              state <= WDATA;
            end
            RDATA: if (byte_done) begin
              sda_oe <= 1'b0;
              state <= RDATA_ACK;
            end else sda_oe <= ~shreg[7];
            RDATA_ACK: begin
              bit_cnt <= '0;
              REG_RE <= ~nack;
              REG_ADDR <= nack ? REG_ADDR : next_ptr;
              state <= nack ? IGNORE : RDATA;
            end
            default: ;
          endcase
      end
    end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: directed bus-master bench for i2c_reg_target (expectations follow I2C_TARGET_AUTOINC_EN)
module tb_i2c_reg_target;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  wire sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, busy;
  int total = 0, bad = 0, re_cnt = 0;
  logic [15:0] we_q[$];
`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  always #5 clk = ~clk;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign reg_rdata = ~reg_addr;

  i2c_reg_target dut (
    .iCLK(clk), .iRST_N(rst_n), .I2C_SCL(m_scl), .I2C_SDA(sda),
    .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we),
    .REG_RDATA(reg_rdata), .REG_RE(reg_re), .BUSY(busy)
  );

  always @(posedge clk) begin
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_cnt++;
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    wq(2); m_sda = 1'b1; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b0; wq(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_stop;
    wq(2); m_sda = 1'b0; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b1; wq(Q);
  endtask

  // glitch selects a bit whose low phase carries a one-iCLK SCL pulse (-1: none)
  task automatic send_bits(input logic [7:0] b, input int glitch);
    for (int i = 7; i >= 0; i--) begin
      wq(2); m_sda = b[i]; wq(4);
      if (i == glitch) begin
        m_scl = 1'b1; wq(1); m_scl = 1'b0;
      end
      wq(Q); m_scl = 1'b1; wq(Q); m_scl = 1'b0;
    end
  endtask

  task automatic get_ack(output logic ack);
    wq(2); m_sda = 1'b1; wq(Q); m_scl = 1'b1; wq(Q); ack = (sda == 1'b0); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, -1);
    get_ack(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    b = '0;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq(2); wq(Q); m_scl = 1'b1; wq(Q); b = {b[6:0], sda}; m_scl = 1'b0;
    end
    wq(2); m_sda = ~ack; wq(Q); m_scl = 1'b1; wq(Q); m_scl = 1'b0; wq(2); m_sda = 1'b1;
  endtask

  task automatic test_reset;
    total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
    total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", reg_we); end
    total++; if (reg_re !== 1'b0) begin bad++; $display("FAIL reset_re got=%b exp=0", reg_re); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda); end
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    logic [15:0] e0;
    int n0 = we_q.size();
    i2c_start;
    write_byte(8'h72, a0); write_byte(8'h41, a1); write_byte(8'h10, a2);
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL write_acks got=%b%b%b exp=111", a0, a1, a2); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_mid got=%b exp=1", busy); end
    i2c_stop;
    e0 = we_q.size() > n0 ? we_q[n0] : 16'h0000;
    total++; if (we_q.size() != n0 + 1) begin bad++; $display("FAIL write_we_count got=%0d exp=1", we_q.size() - n0); end
    total++; if (e0 !== 16'h4110) begin bad++; $display("FAIL write_we_data got=%h exp=4110", e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_burst;
    logic a0, a1, a2, a3;
    logic [15:0] e0, e1;
    int n0 = we_q.size();
    i2c_start;
    write_byte(8'h72, a0); write_byte(8'hA4, a1); write_byte(8'h08, a2); write_byte(8'h04, a3);
    i2c_stop;
    e0 = we_q.size() > n0 ? we_q[n0] : 16'h0000;
    e1 = we_q.size() > n0 + 1 ? we_q[n0 + 1] : 16'h0000;
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL burst_acks got=%b%b%b%b exp=1111", a0, a1, a2, a3); end
    total++; if (we_q.size() != n0 + 2) begin bad++; $display("FAIL burst_we_count got=%0d exp=2", we_q.size() - n0); end
    total++; if (e0 !== 16'hA408) begin bad++; $display("FAIL burst_we0 got=%h exp=a408", e0); end
    total++; if (e1 !== (AUTOINC ? 16'hA504 : 16'hA404)) begin bad++; $display("FAIL burst_we1 got=%h exp=%h", e1, AUTOINC ? 16'hA504 : 16'hA404); end
  endtask

  task automatic test_read;
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    int r0 = re_cnt;
    i2c_start;
    write_byte(8'h72, a0); write_byte(8'h16, a1);
    i2c_start;
    write_byte(8'h73, a2);
    read_byte(1'b1, d0); read_byte(1'b1, d1); read_byte(1'b0, d2);
    wq(Q);
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL read_release got=%b exp=1", sda); end
    i2c_stop;
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL read_acks got=%b%b%b exp=111", a0, a1, a2); end
    total++; if (d0 !== 8'hE9) begin bad++; $display("FAIL read_d0 got=%h exp=e9", d0); end
    total++; if (d1 !== (AUTOINC ? 8'hE8 : 8'hE9)) begin bad++; $display("FAIL read_d1 got=%h exp=%h", d1, AUTOINC ? 8'hE8 : 8'hE9); end
    total++; if (d2 !== (AUTOINC ? 8'hE7 : 8'hE9)) begin bad++; $display("FAIL read_d2 got=%h exp=%h", d2, AUTOINC ? 8'hE7 : 8'hE9); end
    total++; if (re_cnt - r0 != 3) begin bad++; $display("FAIL read_re_count got=%0d exp=3", re_cnt - r0); end
  endtask

  task automatic test_bad_addr;
    logic a0, a1, a2, a3;
    int n0 = we_q.size();
    int r0 = re_cnt;
    i2c_start;
    write_byte(8'h74, a0); write_byte(8'h41, a1); write_byte(8'h55, a1);
    i2c_stop;
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL bad_addr_ack got=%b exp=0", a0); end
    total++; if (we_q.size() != n0 || re_cnt != r0) begin bad++; $display("FAIL bad_addr_strobes got=%0d/%0d exp=0/0", we_q.size() - n0, re_cnt - r0); end
    i2c_start;
    write_byte(8'h72, a2); write_byte(8'h20, a3);
    i2c_stop;
    total++; if ({a2, a3} !== 2'b11) begin bad++; $display("FAIL bad_addr_recover got=%b%b exp=11", a2, a3); end
  endtask

  task automatic test_wrap;
    logic a0, a1, a2, a3;
    logic [15:0] e0, e1;
    int n0 = we_q.size();
    i2c_start;
    write_byte(8'h72, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
    i2c_stop;
    e0 = we_q.size() > n0 ? we_q[n0] : 16'h0000;
    e1 = we_q.size() > n0 + 1 ? we_q[n0 + 1] : 16'h0000;
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wrap_acks got=%b%b%b%b exp=1111", a0, a1, a2, a3); end
    total++; if (e0 !== 16'hFF11) begin bad++; $display("FAIL wrap_we0 got=%h exp=ff11", e0); end
    total++; if (e1 !== (AUTOINC ? 16'h0022 : 16'hFF22)) begin bad++; $display("FAIL wrap_we1 got=%h exp=%h", e1, AUTOINC ? 16'h0022 : 16'hFF22); end
  endtask

  task automatic test_async_reset;
    logic a0;
    i2c_start;
    send_bits(8'h72, -1);
    wq(2); m_sda = 1'b1; wq(Q);
    total++; if (sda !== 1'b0) begin bad++; $display("FAIL arst_ack_before got=%b exp=0", sda); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL arst_sda got=%b exp=1", sda); end
    total++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin bad++; $display("FAIL arst_regs got=%h/%h exp=00/00", reg_addr, reg_wdata); end
    total++; if (busy !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0) begin bad++; $display("FAIL arst_ctl got=%b%b%b exp=000", busy, reg_we, reg_re); end
    wq(3); m_scl = 1'b1; wq(1); rst_n = 1'b1; wq(Q);
    i2c_start;
    send_bits(8'h72, 3);
    get_ack(a0);
    i2c_stop;
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL glitch_ack got=%b exp=1", a0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  initial begin
    wq(4); rst_n = 1'b1; wq(4);
    test_reset;
    test_write;
    test_burst;
    test_read;
    test_bad_addr;
    test_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
